// File: rtl/uart_rx_buffer_cti.sv
// uart_rx_buffer_cti
// Receive character buffer between the UART deserialiser and the register block.
// First-word-fall-through FIFO with a programmable trigger level, sticky overrun
// and a 16550-style character-timeout (CTI) indication.
// Build option: define UART_RX_BUF_ERRFLAG_EN to store parity/framing flags per
// entry and to report err_in_fifo_o. Without it the flag outputs are tied low.
//
// CTI FSM states
//   state | meaning
//   IDLE  | FIFO empty, timeout counter held at 0
//   COUNT | data held, counting idle baud ticks since the last push/pop
//   FIRED | timeout reached, cti_o asserted until push, pop, empty or clear

module uart_rx_buffer_cti #(
    parameter int DATA_WIDTH    = 8,
    parameter int DEPTH         = 16,
    parameter int TIMEOUT_CHARS = 4
) (
    input  logic                    CLK,
    input  logic                    RESETN,
    input  logic                    clr_i,
    input  logic                    rx_valid_i,
    input  logic [DATA_WIDTH-1:0]   rx_data_i,
    input  logic                    rx_perr_i,
    input  logic                    rx_ferr_i,
    input  logic                    baud_tick_i,
    input  logic [3:0]              bits_per_char_i,
    input  logic [1:0]              trig_lvl_i,
    input  logic                    rd_en_i,
    output logic [DATA_WIDTH-1:0]   rd_data_o,
    output logic                    rd_perr_o,
    output logic                    rd_ferr_o,
    output logic                    rd_valid_o,
    output logic [$clog2(DEPTH):0]  count_o,
    output logic                    rda_o,
    output logic                    cti_o,
    output logic                    overrun_o,
    input  logic                    ovr_clr_i,
    output logic                    err_in_fifo_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(TIMEOUT_CHARS * 12 + 1);
`ifdef UART_RX_BUF_ERRFLAG_EN
    localparam int EW = DATA_WIDTH + 2;
`else
    localparam int EW = DATA_WIDTH;
`endif

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        FIRED = 2'd2
    } cti_state_t;

    logic [EW-1:0]  mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [CW-1:0]  count;
    logic [CW-1:0]  count_next;
    logic           empty;
    logic           full;
    logic           do_push;
    logic           do_pop;
    logic           overrun_set;
    logic [EW-1:0]  wr_entry;
    logic [EW-1:0]  head;

    cti_state_t     state;
    logic [TW-1:0]  tmr;
    logic [TW-1:0]  tmr_inc;
    logic [TW-1:0]  limit;
    logic [3:0]     bits_eff;
    logic           activity;

    assign empty       = (count == '0);
    assign full        = (count == CW'(DEPTH));
    // A pop makes room, so a push into a full FIFO is accepted in the same cycle.
    assign do_pop      = rd_en_i & ~empty & ~clr_i;
    assign do_push     = rx_valid_i & ~clr_i & (~full | do_pop);
    assign overrun_set = rx_valid_i & ~clr_i & full & ~do_pop;
    assign head        = mem[rd_ptr];
    assign activity    = do_push | do_pop;

    // Next fill level; clear has priority over push and pop.
    always_comb begin
        count_next = count;
        if (clr_i)
            count_next = '0;
        else if (do_push && !do_pop)
            count_next = count + CW'(1);
        else if (do_pop && !do_push)
            count_next = count - CW'(1);
    end

    // Character storage, intentionally not reset.
    always_ff @(posedge CLK) begin
        if (do_push)
            mem[wr_ptr] <= wr_entry;
    end

    // Pointers and fill counter.
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            count <= count_next;
            if (clr_i) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (do_push)
                    wr_ptr <= wr_ptr + AW'(1);
                if (do_pop)
                    rd_ptr <= rd_ptr + AW'(1);
            end
        end
    end

    // Sticky overrun; a new overrun beats a simultaneous clear.
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN)
            overrun_o <= 1'b0;
        else if (overrun_set)
            overrun_o <= 1'b1;
        else if (ovr_clr_i)
            overrun_o <= 1'b0;
    end

    assign rd_valid_o = ~empty;
    assign count_o    = count;
    assign rd_data_o  = empty ? '0 : head[DATA_WIDTH-1:0];

    // Receive-data-available against the selected trigger level.
    always_comb begin
        rda_o = 1'b0;
        case (trig_lvl_i)
            2'b00:   rda_o = (count >= CW'(1));
            2'b01:   rda_o = (count >= CW'(DEPTH / 4));
            2'b10:   rda_o = (count >= CW'(DEPTH / 2));
            default: rda_o = (count >= CW'(DEPTH - 2));
        endcase
    end

    // Character length clamped to the legal 7..12 bit range.
    always_comb begin
        bits_eff = bits_per_char_i;
        if (bits_per_char_i < 4'd7)
            bits_eff = 4'd7;
        else if (bits_per_char_i > 4'd12)
            bits_eff = 4'd12;
    end

    assign limit   = TW'(TIMEOUT_CHARS * int'(bits_eff));
    assign tmr_inc = tmr + TW'(1);

    // Character-timeout FSM with registered cti_o.
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            state <= IDLE;
            tmr   <= '0;
            cti_o <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    tmr   <= '0;
                    cti_o <= 1'b0;
                    if (count_next != '0)
                        state <= COUNT;
                end
                COUNT: begin
                    if (count_next == '0) begin
                        state <= IDLE;
                        tmr   <= '0;
                    end else if (activity) begin
                        tmr <= '0;
                    end else if (baud_tick_i) begin
                        tmr <= tmr_inc;
                        if (tmr_inc >= limit) begin
                            state <= FIRED;
                            cti_o <= 1'b1;
                        end
                    end
                end
                FIRED: begin
                    if (count_next == '0) begin
                        state <= IDLE;
                        tmr   <= '0;
                        cti_o <= 1'b0;
                    end else if (activity) begin
                        state <= COUNT;
                        tmr   <= '0;
                        cti_o <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    tmr   <= '0;
                    cti_o <= 1'b0;
                end
            endcase
        end
    end

`ifdef UART_RX_BUF_ERRFLAG_EN
    logic [CW-1:0] err_cnt;
    logic          err_push;
    logic          err_pop;

    assign wr_entry = {rx_ferr_i, rx_perr_i, rx_data_i};
    assign err_push = do_push & (rx_perr_i | rx_ferr_i);
    assign err_pop  = do_pop & (head[DATA_WIDTH] | head[DATA_WIDTH+1]);

    // Saturating count of stored entries that carry an error flag.
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN)
            err_cnt <= '0;
        else if (clr_i)
            err_cnt <= '0;
        else if (err_push && !err_pop && err_cnt != CW'(DEPTH))
            err_cnt <= err_cnt + CW'(1);
        else if (err_pop && !err_push && err_cnt != '0)
            err_cnt <= err_cnt - CW'(1);
    end

    assign err_in_fifo_o = (err_cnt != '0);
    assign rd_perr_o     = ~empty & head[DATA_WIDTH];
    assign rd_ferr_o     = ~empty & head[DATA_WIDTH+1];
`else
    logic unused_err;

    assign wr_entry      = rx_data_i;
    assign unused_err    = rx_perr_i ^ rx_ferr_i;
    assign err_in_fifo_o = 1'b0;
    assign rd_perr_o     = 1'b0;
    assign rd_ferr_o     = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_buffer_cti.sv
// Bench for uart_rx_buffer_cti (DATA_WIDTH=8, DEPTH=16, TIMEOUT_CHARS=4).
// Pushed characters go into an expected queue; a monitor pops and compares on
// every accepted read. Status outputs are checked against hand-derived values.

module tb_uart_rx_buffer_cti;

    localparam int DW    = 8;
    localparam int DEPTH = 16;
`ifdef UART_RX_BUF_ERRFLAG_EN
    localparam bit FLAGS_EN = 1'b1;
`else
    localparam bit FLAGS_EN = 1'b0;
`endif

    logic          CLK = 1'b0;
    logic          RESETN;
    logic          clr;
    logic          rx_valid;
    logic [DW-1:0] rx_data;
    logic          rx_perr;
    logic          rx_ferr;
    logic          baud_tick;
    logic [3:0]    bits_per_char;
    logic [1:0]    trig_lvl;
    logic          rd_en;
    logic [DW-1:0] rd_data;
    logic          rd_perr;
    logic          rd_ferr;
    logic          rd_valid;
    logic [4:0]    count;
    logic          rda;
    logic          cti;
    logic          overrun;
    logic          ovr_clr;
    logic          err_in_fifo;

    int checks = 0;
    int errors = 0;
    logic [DW+1:0] expq[$];
    logic [DW+1:0] mon_e;

    uart_rx_buffer_cti #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .TIMEOUT_CHARS(4)) dut (
        .CLK             (CLK),
        .RESETN          (RESETN),
        .clr_i           (clr),
        .rx_valid_i      (rx_valid),
        .rx_data_i       (rx_data),
        .rx_perr_i       (rx_perr),
        .rx_ferr_i       (rx_ferr),
        .baud_tick_i     (baud_tick),
        .bits_per_char_i (bits_per_char),
        .trig_lvl_i      (trig_lvl),
        .rd_en_i         (rd_en),
        .rd_data_o       (rd_data),
        .rd_perr_o       (rd_perr),
        .rd_ferr_o       (rd_ferr),
        .rd_valid_o      (rd_valid),
        .count_o         (count),
        .rda_o           (rda),
        .cti_o           (cti),
        .overrun_o       (overrun),
        .ovr_clr_i       (ovr_clr),
        .err_in_fifo_o   (err_in_fifo)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
        end
    endtask

    // Monitor: every accepted read is compared against the queue head.
    always @(posedge CLK) begin
        if (RESETN && rd_en && rd_valid) begin
            if (expq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL pop_unexpected: got data 0x%0h, expected no entry at %0t", rd_data, $time);
            end else begin
                mon_e = expq.pop_front();
                chk("pop_data", int'(rd_data), int'(mon_e[DW-1:0]));
                chk("pop_perr", int'(rd_perr), int'(mon_e[DW]));
                chk("pop_ferr", int'(rd_ferr), int'(mon_e[DW+1]));
            end
        end
    end

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic push(input logic [DW-1:0] d, input logic pe, input logic fe);
        rx_data  = d;
        rx_perr  = pe;
        rx_ferr  = fe;
        rx_valid = 1'b1;
        if (expq.size() < DEPTH)
            expq.push_back({fe & FLAGS_EN, pe & FLAGS_EN, d});
        cyc();
        rx_valid = 1'b0;
        rx_perr  = 1'b0;
        rx_ferr  = 1'b0;
    endtask

    task automatic pop();
        rd_en = 1'b1;
        cyc();
        rd_en = 1'b0;
    endtask

    task automatic pushpop(input logic [DW-1:0] d);
        rx_data  = d;
        rx_valid = 1'b1;
        rd_en    = 1'b1;
        expq.push_back({2'b00, d});
        cyc();
        rx_valid = 1'b0;
        rd_en    = 1'b0;
    endtask

    task automatic do_clr();
        clr = 1'b1;
        cyc();
        clr = 1'b0;
        expq.delete();
    endtask

    task automatic pulse_ovr_clr();
        ovr_clr = 1'b1;
        cyc();
        ovr_clr = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            baud_tick = 1'b1;
            cyc();
            baud_tick = 1'b0;
            cyc();
        end
    endtask

    initial begin
        RESETN = 1'b0; clr = 1'b0; rx_valid = 1'b0; rx_data = '0; rx_perr = 1'b0;
        rx_ferr = 1'b0; baud_tick = 1'b0; bits_per_char = 4'd10; trig_lvl = 2'b00;
        rd_en = 1'b0; ovr_clr = 1'b0;
        repeat (3) cyc();

        chk("rst_count", int'(count), 0);
        chk("rst_rd_valid", int'(rd_valid), 0);
        chk("rst_rda", int'(rda), 0);
        chk("rst_cti", int'(cti), 0);
        chk("rst_overrun", int'(overrun), 0);
        chk("rst_err", int'(err_in_fifo), 0);
        chk("rst_rd_data", int'(rd_data), 0);
        RESETN = 1'b1;
        cyc();

        // In-order FWFT read of three characters.
        push(8'h41, 1'b0, 1'b0);
        chk("t1_head_visible", int'(rd_data), 'h41);
        push(8'h42, 1'b0, 1'b0);
        push(8'h43, 1'b0, 1'b0);
        chk("t1_count3", int'(count), 3);
        repeat (3) pop();
        chk("t1_count0", int'(count), 0);
        chk("t1_rd_valid0", int'(rd_valid), 0);

        // Read while empty is harmless.
        pop();
        chk("empty_pop_count", int'(count), 0);
        chk("empty_pop_overrun", int'(overrun), 0);

        // Fill past full: 17th character dropped, overrun set then cleared.
        for (int i = 0; i < 17; i++) push(8'(8'h10 + i), 1'b0, 1'b0);
        chk("t2_count_full", int'(count), 16);
        chk("t2_overrun_set", int'(overrun), 1);
        pulse_ovr_clr();
        chk("t2_overrun_clr", int'(overrun), 0);

        // Push and pop together while full.
        pushpop(8'hA5);
        chk("t3_count_full", int'(count), 16);
        chk("t3_no_overrun", int'(overrun), 0);
        repeat (16) pop();
        chk("t3_drained", int'(count), 0);

        // Trigger levels.
        trig_lvl = 2'b10;
        for (int i = 0; i < 7; i++) push(8'(8'h30 + i), 1'b0, 1'b0);
        chk("t4_rda_7of8", int'(rda), 0);
        trig_lvl = 2'b01;
        #1;
        chk("t4_rda_quarter", int'(rda), 1);
        trig_lvl = 2'b10;
        push(8'h37, 1'b0, 1'b0);
        chk("t4_rda_8of8", int'(rda), 1);
        pop();
        chk("t4_rda_after_pop", int'(rda), 0);
        repeat (7) pop();
        trig_lvl = 2'b00;

        // Character timeout: 4 chars x 10 bits = 40 ticks.
        push(8'h61, 1'b0, 1'b0);
        ticks(39);
        chk("t5_cti_tick39", int'(cti), 0);
        ticks(1);
        chk("t5_cti_tick40", int'(cti), 1);
        pop();
        chk("t5_cti_cleared_pop", int'(cti), 0);
        push(8'h62, 1'b0, 1'b0);
        ticks(39);
        push(8'h63, 1'b0, 1'b0);
        ticks(39);
        chk("t5_cti_restarted", int'(cti), 0);
        ticks(1);
        chk("t5_cti_after_restart", int'(cti), 1);
        push(8'h64, 1'b0, 1'b0);
        chk("t5_cti_cleared_push", int'(cti), 0);
        do_clr();
        chk("t5_clr_count", int'(count), 0);
        chk("t5_clr_cti", int'(cti), 0);

        // Short character length clamps to 7 bits: 28 ticks.
        bits_per_char = 4'd3;
        push(8'h65, 1'b0, 1'b0);
        ticks(27);
        chk("clamp_cti_tick27", int'(cti), 0);
        ticks(1);
        chk("clamp_cti_tick28", int'(cti), 1);
        pop();
        bits_per_char = 4'd10;

`ifdef UART_RX_BUF_ERRFLAG_EN
        for (int i = 0; i < 17; i++) push(8'(8'h90 + i), 1'b0, 1'b0);
        do_clr();
        push(8'h55, 1'b1, 1'b0);
        push(8'h66, 1'b0, 1'b0);
        chk("t6_err_set", int'(err_in_fifo), 1);
        chk("t6_head_perr", int'(rd_perr), 1);
        pop();
        chk("t6_err_after_pop", int'(err_in_fifo), 0);
        push(8'h77, 1'b0, 1'b1);
        push(8'h88, 1'b0, 1'b0);
        chk("t6_count3", int'(count), 3);
        chk("t6_err_ferr", int'(err_in_fifo), 1);
        do_clr();
        chk("t6_clr_count", int'(count), 0);
        chk("t6_clr_err", int'(err_in_fifo), 0);
        chk("t6_overrun_kept", int'(overrun), 1);
        pulse_ovr_clr();
`else
        push(8'h55, 1'b1, 1'b1);
        chk("noflag_err", int'(err_in_fifo), 0);
        chk("noflag_perr", int'(rd_perr), 0);
        chk("noflag_ferr", int'(rd_ferr), 0);
        pop();
`endif

        // Asynchronous reset in the middle of a cycle.
        for (int i = 0; i < 17; i++) push(8'(8'h80 + i), 1'b0, 1'b0);
        chk("arst_pre_overrun", int'(overrun), 1);
        #2;
        RESETN = 1'b0;
        #1;
        chk("arst_count", int'(count), 0);
        chk("arst_rd_valid", int'(rd_valid), 0);
        chk("arst_rd_data", int'(rd_data), 0);
        chk("arst_overrun", int'(overrun), 0);
        expq.delete();
        cyc();
        RESETN = 1'b1;
        cyc();
        push(8'h5A, 1'b0, 1'b0);
        pop();
        chk("post_rst_count", int'(count), 0);

        chk("scoreboard_empty", expq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
